systolic_skew_feeder: RTL and testbench

Upstream feeder for the systolic array layer. It accepts matrix `a` one row per handshake and emits the skewed diagonal stream the array consumes on its `in_data`, `in_valid` and `in_start` ports. It pads with zeros and flushes the tail of each matrix so the array's diagonal input format is met without software pre-skewing. One instance sits in front of each array, and its outputs connect straight to the array.

---
 rtl/systolic_skew_feeder.sv | 104 ++++++++++
 tb/tb_systolic_skew_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Row-to-diagonal skew feeder for a systolic array: lane k delays column k by k
// advances, then zero-fills the tail of each matrix during FLUSH.
module systolic_skew_feeder #(
  parameter int BitSize     = 8,
  parameter int NumOfInputs = 4
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [NumOfInputs*BitSize-1:0] in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic                           out_start,
  output logic                           out_done,
  output logic [NumOfInputs*BitSize-1:0] out_data
);
  localparam int CntW = $clog2(NumOfInputs) + 1;
  // Count value on the final FLUSH advance (n-1 advances in total).
  localparam logic [CntW-1:0] FlushLast = CntW'((NumOfInputs > 1) ? NumOfInputs - 2 : 0);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t             state_reg;
  logic [CntW-1:0]    flush_cnt_reg;
  logic               flushing;
  logic               acc;
  logic               adv;
  logic               first_row;
  logic               done_bit;
  logic [BitSize-1:0] tap [NumOfInputs];

  assign flushing  = (state_reg == FLUSH);
  assign in_ready  = !flushing;
  assign acc       = in_valid & in_ready;
  assign adv       = acc | flushing;
  assign first_row = acc & (state_reg == IDLE);
  assign done_bit  = (NumOfInputs == 1) ? (acc & in_last)
                                        : (flushing & (flush_cnt_reg == FlushLast));

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      out_valid     <= 1'b0;
      out_start     <= 1'b0;
      out_done      <= 1'b0;
    end else begin
      out_valid <= adv;
      out_start <= adv & first_row;
      out_done  <= adv & done_bit;
      case (state_reg)
        IDLE, STREAM: begin
          if (acc) begin
            if (!in_last) begin
              state_reg <= STREAM;
            end else if (NumOfInputs > 1) begin
              state_reg     <= FLUSH;
              flush_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FlushLast) state_reg <= IDLE;
          flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumOfInputs; gi++) begin : g_lane
      logic [BitSize-1:0] lane_in;
      assign lane_in = flushing ? '0 : in_data[(NumOfInputs-gi)*BitSize-1 -: BitSize];
      if (gi == 0) begin : g_direct
        assign tap[gi] = lane_in;
      end else begin : g_delay
        logic [BitSize-1:0] line_reg [gi];
        always_ff @(posedge clk) begin
          if (res) begin
            for (int j = 0; j < gi; j++) line_reg[j] <= '0;
          end else if (adv) begin
            line_reg[0] <= lane_in;
            for (int j = 1; j < gi; j++) line_reg[j] <= line_reg[j-1];
          end
        end
        assign tap[gi] = line_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res) begin
      out_data <= '0;
    end else if (adv) begin
      for (int k = 0; k < NumOfInputs; k++)
        out_data[(NumOfInputs-k)*BitSize-1 -: BitSize] <= tap[k];
    end
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a directed vector table, hand sequences and
// randomized matrices checked against a diagonal-formula reference model.
module tb_systolic_skew_feeder;
  localparam int B = 8;
  localparam int N = 4;
  localparam int W = B * N;

  logic         clk = 1'b0;
  logic         res;
  logic         in_valid, in_last;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_start, out_done;
  logic [W-1:0] out_data;

  logic         v1, l1;
  logic [B-1:0] d1;
  logic         r1, ov1, os1, od1;
  logic [B-1:0] o1;

  systolic_skew_feeder #(.BitSize(B), .NumOfInputs(N)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_start(out_start),
    .out_done(out_done), .out_data(out_data));

  systolic_skew_feeder #(.BitSize(B), .NumOfInputs(1)) dut1 (
    .clk(clk), .res(res), .in_valid(v1), .in_last(l1), .in_data(d1),
    .in_ready(r1), .out_valid(ov1), .out_start(os1), .out_done(od1), .out_data(o1));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] p4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] e);
    return {a, b, c, e};
  endfunction

  function automatic logic [W-1:0] mk_row(input int base, input int r);
    logic [W-1:0] v = '0;
    for (int k = 0; k < N; k++) v[(N-k)*B-1 -: B] = 8'(base + 16 * r + k);
    return v;
  endfunction

  // Reference model: diagonal d carries a[d-k][k] on lane k, zero outside the matrix.
  logic [W-1:0] rows [$];
  int           adv_idx    = 0;
  bit           last_seen  = 0;
  int           flush_left = 0;
  logic [W-1:0] exp_data   = '0;

  function automatic logic [W-1:0] diag(input int d);
    logic [W-1:0] v = '0;
    for (int k = 0; k < N; k++)
      if (d - k >= 0 && d - k < rows.size())
        v[(N-k)*B-1 -: B] = rows[d-k][(N-k)*B-1 -: B];
    return v;
  endfunction

  task automatic model_clear();
    rows.delete();
    adv_idx = 0; last_seen = 0; flush_left = 0; exp_data = '0;
  endtask

  task automatic mcycle(input logic v, input logic l, input logic [W-1:0] d, output bit accepted);
    bit rdy, adv, st, dn;
    in_valid = v; in_last = l; in_data = d;
    rdy = (flush_left == 0);
    #1;
    check("in_ready", in_ready, rdy);
    accepted = v && rdy;
    adv = accepted || (flush_left > 0);
    st = 0; dn = 0;
    if (accepted) begin
      rows.push_back(d);
      if (l) last_seen = 1;
    end
    if (adv) begin
      exp_data = diag(adv_idx);
      st = (adv_idx == 0);
      dn = last_seen && (adv_idx == rows.size() + N - 2);
      adv_idx++;
    end
    if (flush_left > 0) flush_left--;
    else if (accepted && l) flush_left = N - 1;
    @(posedge clk); #1;
    check("out_valid", out_valid, adv);
    check("out_start", out_start, st);
    check("out_done", out_done, dn);
    check("out_data", out_data, exp_data);
    if (dn) begin
      rows.delete(); adv_idx = 0; last_seen = 0;
    end
  endtask

  task automatic send_matrix(input int m, input bit rnd, input int base);
    bit a;
    logic [W-1:0] row;
    for (int r = 0; r < m; r++) begin
      row = rnd ? W'($urandom) : mk_row(base, r);
      if (rnd) while ($urandom_range(0, 2) == 0) mcycle(1'b0, 1'($urandom_range(0, 1)), W'($urandom), a);
      a = 0;
      for (int t = 0; t < 10 && !a; t++) mcycle(1'b1, r == m - 1, row, a);
      checks++;
      if (!a) begin
        fails++;
        $display("FAIL row_accept: row %0d not accepted within 10 cycles", r);
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) mcycle(1'b0, 1'b0, '0, a);
  endtask

  typedef struct {
    logic         v, l;
    logic [W-1:0] d;
    logic         rdy, ov, os, od;
    logic [W-1:0] data;
  } vec_t;
  vec_t tbl [8];

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v; in_last = tbl[i].l; in_data = tbl[i].d;
      #1;
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("tbl%0d_out_start", i), out_start, tbl[i].os);
      check($sformatf("tbl%0d_out_done", i), out_done, tbl[i].od);
      check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].data);
    end
    exp_data = tbl[7].data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit a;
    logic [B-1:0] n1_in   [4] = '{8'd3, 8'd4, 8'd9, 8'd0};
    logic         n1_v    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic         n1_l    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         n1_ov   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic         n1_os   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic         n1_od   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [B-1:0] n1_data [4] = '{8'd3, 8'd4, 8'd9, 8'd9};

    // Entry i: inputs in cycle i and in_ready in cycle i; outputs observed in cycle i+1.
    tbl[0] = '{1'b1, 1'b0, p4(8'h00, 8'h01, 8'h02, 8'h03), 1'b1, 1'b1, 1'b1, 1'b0, p4(8'h00, 8'h00, 8'h00, 8'h00)};
    tbl[1] = '{1'b1, 1'b0, p4(8'h10, 8'h11, 8'h12, 8'h13), 1'b1, 1'b1, 1'b0, 1'b0, p4(8'h10, 8'h01, 8'h00, 8'h00)};
    tbl[2] = '{1'b1, 1'b0, p4(8'h20, 8'h21, 8'h22, 8'h23), 1'b1, 1'b1, 1'b0, 1'b0, p4(8'h20, 8'h11, 8'h02, 8'h00)};
    tbl[3] = '{1'b1, 1'b1, p4(8'h30, 8'h31, 8'h32, 8'h33), 1'b1, 1'b1, 1'b0, 1'b0, p4(8'h30, 8'h21, 8'h12, 8'h03)};
    tbl[4] = '{1'b0, 1'b0, p4(8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b1, 1'b0, 1'b0, p4(8'h00, 8'h31, 8'h22, 8'h13)};
    tbl[5] = '{1'b1, 1'b1, p4(8'hee, 8'hee, 8'hee, 8'hee), 1'b0, 1'b1, 1'b0, 1'b0, p4(8'h00, 8'h00, 8'h32, 8'h23)};
    tbl[6] = '{1'b0, 1'b0, p4(8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b1, 1'b0, 1'b1, p4(8'h00, 8'h00, 8'h00, 8'h33)};
    tbl[7] = '{1'b0, 1'b0, p4(8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0, 1'b0, 1'b0, p4(8'h00, 8'h00, 8'h00, 8'h33)};

    res = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    v1 = 1'b0; l1 = 1'b0; d1 = '0;
    @(posedge clk); @(posedge clk); #1;
    res = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_start", out_start, 1'b0);
    check("rst_out_done", out_done, 1'b0);
    check("rst_out_data", out_data, '0);
    #1;
    model_clear();

    run_table();

    // Input gap after row 1: out_valid drops one cycle, data holds, done slips a cycle.
    mcycle(1'b1, 1'b0, mk_row(0, 0), a);
    mcycle(1'b1, 1'b0, mk_row(0, 1), a);
    mcycle(1'b0, 1'b1, '0, a);
    check("gap_hold_data", out_data, p4(8'h10, 8'h01, 8'h00, 8'h00));
    mcycle(1'b1, 1'b0, mk_row(0, 2), a);
    mcycle(1'b1, 1'b1, mk_row(0, 3), a);
    idle(4);

    // Single-row matrix.
    mcycle(1'b1, 1'b1, p4(8'd5, 8'd6, 8'd7, 8'd8), a);
    idle(4);

    // Back-to-back 2x4 matrices; the second is offered during the flush.
    send_matrix(2, 1'b0, 8'h40);
    send_matrix(2, 1'b0, 8'h80);
    idle(4);

    // Reset in cycle 5 of the 4x4 scenario, then the scenario must repeat exactly.
    for (int r = 0; r < 4; r++) mcycle(1'b1, r == 3, mk_row(0, r), a);
    mcycle(1'b0, 1'b0, '0, a);
    res = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    res = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_start", out_start, 1'b0);
    check("midrst_out_done", out_done, 1'b0);
    check("midrst_out_data", out_data, '0);
    model_clear();
    run_table();

    for (int i = 0; i < 30; i++) begin
      send_matrix($urandom_range(1, 6), 1'b1, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(N + 1);

    // NumOfInputs = 1: no flush, in_ready never drops.
    for (int i = 0; i < 4; i++) begin
      v1 = n1_v[i]; l1 = n1_l[i]; d1 = n1_in[i];
      #1;
      check($sformatf("n1_%0d_in_ready", i), r1, 1'b1);
      @(posedge clk); #1;
      check($sformatf("n1_%0d_out_valid", i), ov1, n1_ov[i]);
      check($sformatf("n1_%0d_out_start", i), os1, n1_os[i]);
      check($sformatf("n1_%0d_out_done", i), od1, n1_od[i]);
      check($sformatf("n1_%0d_out_data", i), o1, n1_data[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
